// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, command codes and parameter defaults for the SDRAM port arbiter
package sdram_arb_pkg;
    typedef enum logic [2:0] {WAIT_INIT, IDLE, WR_BURST, RD_CMD, RD_WAIT, RECOVER} arb_state_t;
    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ = 1'b0;
    localparam int GNT_RD = 0;
    localparam int GNT_WR = 1;
    localparam int DEF_ADDR_WIDTH = 21;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BURST_BEATS = 8;
    localparam int DEF_RECOVERY_CYCLES = 13;
    localparam int DEF_RD_TIMEOUT = 64;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester and memory-controller signal bundle seen by the arbiter
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic init_done;
    logic wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic wr_gnt;
    logic wr_beat_en;
    logic rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic rd_valid_o;
    logic cmd;
    logic cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic rd_data_valid;
    logic error;
    modport arbiter (
        input init_done, wr_req, wr_addr, wr_data_i, rd_req, rd_addr, rd_data, rd_data_valid,
        output wr_gnt, wr_beat_en, rd_gnt, rd_data_o, rd_valid_o, cmd, cmd_en, addr, wr_data, error
    );
    modport client (
        output init_done, wr_req, wr_addr, wr_data_i, rd_req, rd_addr, rd_data, rd_data_valid,
        input wr_gnt, wr_beat_en, rd_gnt, rd_data_o, rd_valid_o, cmd, cmd_en, addr, wr_data, error
    );
endinterface

// File: rtl/sdram_arb_rr_picker.sv
// sdram_arb_rr_picker: two-way round-robin picker; a tie goes to the requester not granted last
module sdram_arb_rr_picker (
    input logic clk,
    input logic rst,
    input logic en,
    input logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_wr;
    always_comb begin
        gnt[1] = req[1] && (!req[0] || !last_wr);
        gnt[0] = req[0] && (!req[1] || last_wr);
    end
    // Reset pretends the last grant was a write so the first tie favours read
    always_ff @(posedge clk) begin
        if (rst) last_wr <= 1'b1;
        else if (en && |gnt) last_wr <= gnt[1];
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: arbitrates one write and one read requester onto a burst-oriented SDRAM controller port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_BEATS = DEF_BURST_BEATS,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input logic clk,
    input logic rst,
    input logic init_done,
    input logic wr_req,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data_i,
    output logic wr_gnt,
    output logic wr_beat_en,
    input logic rd_req,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    output logic rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic rd_valid_o,
    output logic cmd,
    output logic cmd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] rd_data,
    input logic rd_data_valid,
    output logic error
);
    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int RW = $clog2(RECOVERY_CYCLES + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    arb_state_t state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] rec_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0] gnt;
    logic in_idle, beat_last, rd_done, rd_timeout;
    sdram_arb_rr_picker u_picker (.clk, .rst, .en(in_idle), .req({wr_req, rd_req}), .gnt);
    assign in_idle = state == IDLE;
    assign beat_last = beat_cnt == BW'(BURST_BEATS - 1);
    assign rd_done = rd_data_valid && beat_last;
    // Timeout is decided one cycle early so the registered error lands RD_TIMEOUT cycles after cmd_en
    assign rd_timeout = state == RD_WAIT && tmo_cnt == TW'(RD_TIMEOUT - 1) && !rd_done;
    assign wr_data = wr_data_i;
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_INIT;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_INIT: state_nxt = init_done ? IDLE : WAIT_INIT;
            IDLE: state_nxt = gnt[GNT_WR] ? WR_BURST : gnt[GNT_RD] ? RD_CMD : IDLE;
            WR_BURST: state_nxt = beat_last ? RECOVER : WR_BURST;
            RD_CMD: state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = rd_done || rd_timeout ? RECOVER : RD_WAIT;
            RECOVER: state_nxt = rec_cnt == RW'(RECOVERY_CYCLES - 1) ? IDLE : RECOVER;
            default: state_nxt = WAIT_INIT;
        endcase
    end
    always_comb begin
        wr_gnt = in_idle && gnt[GNT_WR];
        rd_gnt = in_idle && gnt[GNT_RD];
        wr_beat_en = state == WR_BURST;
        cmd = state == WR_BURST ? CMD_WRITE : CMD_READ;
        cmd_en = state == RD_CMD || (state == WR_BURST && beat_cnt == '0);
    end
    // Counters clear on every state change, so they never exceed their terminal value
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            rec_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            beat_cnt <= state_nxt != state ? '0 : beat_cnt + BW'(wr_beat_en || (state == RD_WAIT && rd_data_valid));
            rec_cnt <= state == RECOVER && state_nxt == RECOVER ? rec_cnt + 1'b1 : '0;
            tmo_cnt <= state == RD_CMD ? TW'(1) : state == RD_WAIT && state_nxt == RD_WAIT ? tmo_cnt + 1'b1 : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            rd_data_o <= '0;
            rd_valid_o <= 1'b0;
            error <= 1'b0;
        end else begin
            addr <= wr_gnt ? wr_addr : rd_gnt ? rd_addr : addr;
            rd_data_o <= state == RD_WAIT && rd_data_valid ? rd_data : rd_data_o;
            rd_valid_o <= state == RD_WAIT && rd_data_valid;
            error <= rd_timeout || (rd_data_valid && state != RD_WAIT);
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench with a read-data scoreboard and a small memory responder
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sdram_port_arbiter_if bus ();
    sdram_port_arbiter dut (
        .clk(clk), .rst(rst), .init_done(bus.init_done),
        .wr_req(bus.wr_req), .wr_addr(bus.wr_addr), .wr_data_i(bus.wr_data_i),
        .wr_gnt(bus.wr_gnt), .wr_beat_en(bus.wr_beat_en),
        .rd_req(bus.rd_req), .rd_addr(bus.rd_addr), .rd_gnt(bus.rd_gnt),
        .rd_data_o(bus.rd_data_o), .rd_valid_o(bus.rd_valid_o),
        .cmd(bus.cmd), .cmd_en(bus.cmd_en), .addr(bus.addr), .wr_data(bus.wr_data),
        .rd_data(bus.rd_data), .rd_data_valid(bus.rd_data_valid), .error(bus.error)
    );
    typedef struct {
        logic wr_gnt, rd_gnt, wr_beat_en, cmd, cmd_en, rd_valid_o, error;
        logic [20:0] addr;
        logic [31:0] wr_data, rd_data_o;
    } obs_t;
    obs_t s;
    int checks = 0, errors = 0, cyc = 0, err_cnt = 0, rv_cnt = 0, last_cmd_cyc = 0;
    int mem_beats = 0, mem_left = 0, mem_wait = 0, mem_delay = 4;
    logic [31:0] mem_val = '0, mem_base = '0;
    logic [31:0] exp_q[$];
    int gnt_log[$];
    bit fwd_cur = 0, fwd_last = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Samples the current cycle at negedge, then moves to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        s.wr_gnt = bus.wr_gnt; s.rd_gnt = bus.rd_gnt; s.wr_beat_en = bus.wr_beat_en;
        s.cmd = bus.cmd; s.cmd_en = bus.cmd_en; s.rd_valid_o = bus.rd_valid_o; s.error = bus.error;
        s.addr = bus.addr; s.wr_data = bus.wr_data; s.rd_data_o = bus.rd_data_o;
        if (s.error) err_cnt++;
        if (s.rd_valid_o) rv_cnt++;
        if (s.wr_gnt) gnt_log.push_back(1);
        if (s.rd_gnt) gnt_log.push_back(0);
        if (s.cmd_en) begin
            last_cmd_cyc = cyc;
            chk("cmd_addr", 32'(s.addr), 32'(s.cmd ? bus.wr_addr : bus.rd_addr));
        end
        chk("rd_valid_timing", 32'(s.rd_valid_o), 32'(fwd_last));
        if (s.rd_valid_o) begin
            if (exp_q.size() == 0) chk("rd_fwd_unexpected", 32'(s.rd_valid_o), 32'(0));
            else chk("rd_data", s.rd_data_o, exp_q.pop_front());
        end
        fwd_last = fwd_cur;
        @(posedge clk);
        #1;
        fwd_cur = 0;
        bus.rd_data_valid = 1'b0;
        if (s.cmd_en && !s.cmd) begin
            mem_wait = mem_delay;
            mem_left = mem_beats;
            mem_val = mem_base;
        end
        if (mem_left > 0) begin
            if (mem_wait > 0) mem_wait--;
            else begin
                bus.rd_data_valid = 1'b1;
                bus.rd_data = mem_val;
                exp_q.push_back(mem_val);
                fwd_cur = 1;
                mem_val++;
                mem_left--;
            end
        end
    endtask
    task automatic wait_for(input string tag, input int which, input int bound);
        bit hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            tick();
            hit = which == 0 ? s.rd_gnt : which == 1 ? s.wr_gnt : s.error;
        end
        chk(tag, 32'(hit), 32'(1));
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int c0, c1, ce, e0, rv0;
        bit bad;
        bus.init_done = 0; bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data_i = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_data = '0; bus.rd_data_valid = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        tick();
        chk("rst_cmd", 32'(s.cmd), 0); chk("rst_cmd_en", 32'(s.cmd_en), 0);
        chk("rst_addr", 32'(s.addr), 0); chk("rst_wr_gnt", 32'(s.wr_gnt), 0);
        chk("rst_rd_gnt", 32'(s.rd_gnt), 0); chk("rst_beat_en", 32'(s.wr_beat_en), 0);
        chk("rst_rd_valid", 32'(s.rd_valid_o), 0); chk("rst_rd_data", s.rd_data_o, 0);
        chk("rst_error", 32'(s.error), 0);
        // Requests are ignored until the controller reports ready
        bus.wr_req = 1; bus.wr_addr = 21'h096040; bus.wr_data_i = 32'h1;
        bad = 0;
        repeat (10) begin
            tick();
            bad |= s.wr_gnt | s.cmd_en;
        end
        chk("no_gnt_before_init", 32'(bad), 0);
        bus.init_done = 1;
        wait_for("gnt_after_init", 1, 2);
        bus.init_done = 0;
        bus.wr_req = 0;
        for (int k = 0; k < 8; k++) begin
            bus.wr_data_i = 32'(k + 1);
            tick();
            chk("wr_beat_en", 32'(s.wr_beat_en), 1);
            chk("wr_cmd", 32'(s.cmd), 1);
            chk("wr_cmd_en", 32'(s.cmd_en), 32'(k == 0));
            chk("wr_data", s.wr_data, 32'(k + 1));
            if (k == 0) chk("wr_addr", 32'(s.addr), 32'h096040);
        end
        c0 = last_cmd_cyc;
        tick();
        chk("wr_beats_exact", 32'(s.wr_beat_en), 0);
        bus.wr_req = 1;
        wait_for("second_wr_gnt", 1, 40);
        bus.wr_req = 0;
        tick();
        chk("wr_spacing_ok", 32'(last_cmd_cyc - c0 >= 22), 1);
        repeat (25) tick();
        // Both requesters held: grants must alternate starting with read
        mem_beats = 8; mem_delay = 4; mem_base = 32'hB0; bus.rd_addr = 21'h0000C0;
        gnt_log.delete();
        bus.wr_req = 1; bus.rd_req = 1;
        for (int i = 0; i < 300 && gnt_log.size() < 4; i++) tick();
        bus.wr_req = 0; bus.rd_req = 0;
        chk("rr_count", 32'(gnt_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", gnt_log.size() > i ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));
        repeat (30) tick();
        chk("rr_no_error", 32'(err_cnt), 0);
        chk("rr_queue_empty", 32'(exp_q.size()), 0);
        mem_base = 32'hA0; bus.rd_addr = 21'h000100;
        bus.rd_req = 1;
        wait_for("rd_gnt", 0, 40);
        bus.rd_req = 0;
        rv0 = rv_cnt; e0 = err_cnt;
        tick();
        chk("rd_cmd_en", 32'(s.cmd_en), 1); chk("rd_cmd", 32'(s.cmd), 0);
        chk("rd_addr", 32'(s.addr), 32'h000100);
        repeat (20) tick();
        chk("rd_beats", 32'(rv_cnt - rv0), 8);
        chk("rd_no_error", 32'(err_cnt - e0), 0);
        chk("rd_queue_empty", 32'(exp_q.size()), 0);
        repeat (15) tick();
        // Short read: only three beats come back, so the timeout must fire
        mem_beats = 3; mem_base = 32'hC0;
        bus.rd_req = 1;
        wait_for("rd_gnt_short", 0, 40);
        bus.rd_req = 0;
        tick();
        chk("short_cmd_en", 32'(s.cmd_en), 1);
        c1 = last_cmd_cyc; e0 = err_cnt;
        wait_for("timeout_err", 2, 80);
        ce = cyc;
        chk("timeout_at", 32'(ce - c1), 64);
        chk("timeout_single", 32'(err_cnt - e0), 1);
        bus.wr_req = 1;
        wait_for("gnt_after_timeout", 1, 20);
        bus.wr_req = 0;
        chk("recover_len", 32'(cyc - ce), 13);
        repeat (25) tick();
        e0 = err_cnt; rv0 = rv_cnt;
        bus.rd_data_valid = 1; bus.rd_data = 32'hEE;
        tick();
        tick();
        chk("stray_err", 32'(s.error), 1);
        chk("stray_no_valid", 32'(rv_cnt - rv0), 0);
        chk("stray_err_count", 32'(err_cnt - e0), 1);
        // Reset during write beat 4 aborts the burst without an error pulse
        bus.wr_addr = 21'h0ABCDE;
        bus.wr_req = 1;
        wait_for("gnt_pre_rst", 1, 20);
        bus.wr_req = 0;
        repeat (4) tick();
        rst = 1;
        e0 = err_cnt;
        tick();
        chk("beat4_active", 32'(s.wr_beat_en), 1);
        rst = 0;
        tick();
        chk("mid_rst_cmd", 32'(s.cmd), 0); chk("mid_rst_cmd_en", 32'(s.cmd_en), 0);
        chk("mid_rst_addr", 32'(s.addr), 0); chk("mid_rst_beat_en", 32'(s.wr_beat_en), 0);
        chk("mid_rst_wr_gnt", 32'(s.wr_gnt), 0); chk("mid_rst_rd_gnt", 32'(s.rd_gnt), 0);
        chk("mid_rst_rd_valid", 32'(s.rd_valid_o), 0); chk("mid_rst_rd_data", s.rd_data_o, 0);
        chk("mid_rst_error", 32'(s.error), 0);
        bus.wr_req = 1;
        bad = 0;
        repeat (5) begin
            tick();
            bad |= s.wr_gnt | s.cmd_en;
        end
        chk("rst_waits_init", 32'(bad), 0);
        chk("rst_no_error", 32'(err_cnt - e0), 0);
        bus.init_done = 1;
        wait_for("gnt_after_reinit", 1, 2);
        bus.init_done = 0;
        bus.wr_req = 0;
        repeat (30) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
